alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered ALU for the CPU datapath. Replaces the fixed 8-bit, 3-bit-mode ALU.
- Adds carry/borrow chaining (ADC/SBC), shifts and rotates, compare, and a full flag set (zero, carry, negative, overflow).
- Adds a multi-cycle unsigned multiply with a start/busy/done handshake.
- The controller issues an op via enable and samples out and the flags when done is high.

Parameters:
- N, 8, operand and result width (N >= 2)
- MUL_EN, 1, 1 instantiates the multiplier; 0 treats MUL as an undefined mode

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- enable  input  1  start request; sampled at posedge when busy=0
- mode  input  4  operation select (ALU_* codes, 4-bit)
- in_a  input  N  operand A
- in_b  input  N  operand B
- out  output  N  result (low half for MUL)
- out_hi  output  N  high half of MUL product; 0 after any other result-writing op
- busy  output  1  high while a MUL is in progress
- done  output  1  one-cycle pulse: out and flags are valid
- flag_zero  output  1  result == 0
- flag_carry  output  1  carry out / borrow / shifted-out bit
- flag_neg  output  1  result MSB
- flag_ovf  output  1  signed overflow

Behaviour:
- Reset: one clk and reset, both stated above: clk rising edge, reset_n synchronous and active-low. When reset_n=0 at a posedge: out=0, out_hi=0, all flags=0, busy=0, done=0, multiplier state cleared.
- Reset during a MUL aborts it. No done pulse is produced for the aborted op.
- Accept rule: enable=1 and busy=0 at posedge k accepts the op. enable while busy=1 is ignored, with no queuing.
- Single-cycle ops: out and flags are registered at edge k; done=1 for the single cycle after edge k.
- MUL latency:
  - busy=1 after edge k.
  - N shift-add iterations at edges k+1..k+N.
  - {out_hi,out} and flags are written at edge k+N.
  - busy=0 and done=1 after edge k+N.
  - Back-to-back MULs: a new enable is accepted at edge k+N+1 at the earliest.
- Mode codes, 4-bit:
  - 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 ADC, 8 SBC, 9 NOT, 10 SHL, 11 SHR, 12 ROL, 13 ROR, 14 CMP, 15 MUL.
- Arithmetic rules:
  - All arithmetic is computed N+1 bits wide.
  - ADD/ADC/INC: carry = bit N of the sum.
  - ADC adds the current flag_carry as carry-in.
  - SUB/SBC/DEC: carry = borrow (1 when the unsigned a < b + cin).
  - SBC subtracts the current flag_carry.
  - INC/DEC ignore in_b.
  - ovf: the standard two's-complement rule on the operand and result MSBs for ADD/ADC/SUB/SBC/INC/DEC/CMP. ovf=0 for all other ops.
- Logic and shift rules:
  - AND/OR/XOR/NOT (NOT = ~in_a): carry=0.
  - SHL/SHR shift in_a by 1 and fill with 0; carry = the bit shifted out.
  - ROL/ROR rotate in_a by 1 (not through carry); carry = the bit that wrapped.
- CMP: computes in_a - in_b, updates all four flags as SUB, leaves out and out_hi unchanged, and pulses done.
- MUL: unsigned in_a*in_b into 2N bits.
  - zero = (full product == 0).
  - carry = (out_hi != 0).
  - neg = out_hi MSB.
  - ovf=0.
- Flag scope: zero and neg are taken from out for every op except MUL and CMP (CMP uses the difference).
- Undefined mode (MUL with MUL_EN=0): out, out_hi and flags hold; done still pulses.
- Idle: out, out_hi and the flags hold their values between ops. done=0 whenever no op completes.
- Operands for MUL are latched at accept. in_a and in_b may change while busy=1.

Decomposition:
- The ALU_* mode codes (4-bit values above) and the flag bit positions go in the shared parameters include file, replacing the 3-bit codes.
- One sub-module, alu_mul: an N-iteration shift-add unsigned multiplier.
  - Inputs: clk, reset_n, start, a, b.
  - Outputs: busy, done, product[2N-1:0].
  - alu_seq handles the handshake muxing and flag generation.

Test Plan:
- N=8, ADD a=0xFF b=0x01 -> next cycle out=0x00, zero=1, carry=1, ovf=0, done pulse 1 cycle; then ADC a=0x00 b=0x00 -> out=0x01, carry=0.
- ADD a=0x7F b=0x01 -> out=0x80, neg=1, ovf=1, carry=0; SUB a=0x00 b=0x01 -> out=0xFF, carry(borrow)=1, neg=1; SBC a=0x05 b=0x02 with carry=1 -> out=0x02.
- SHL 0x81 -> out=0x02, carry=1; ROR 0x01 -> out=0x80, carry=1; CMP a=0x10 b=0x10 -> zero=1, out unchanged from previous value.
- MUL a=0xFF b=0xFF -> busy high 8 cycles, then out=0x01, out_hi=0xFE, carry=1, done single pulse; enable asserted during busy is ignored (no second done).
- reset_n=0 at the 4th cycle of a MUL -> next cycle busy=0, out=0, out_hi=0, all flags 0, no done; MUL a=3 b=4 issued immediately after -> out=0x0C, out_hi=0x00, carry=0.
- MUL_EN=0 build, mode=15 -> out and flags hold, done pulses once, busy stays 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared mode codes and flag bit positions for the sequential ALU.
// Imported by alu_seq and alu_mul.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_INC = 4'd2,
    ALU_DEC = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_ADC = 4'd7,
    ALU_SBC = 4'd8,
    ALU_NOT = 4'd9,
    ALU_SHL = 4'd10,
    ALU_SHR = 4'd11,
    ALU_ROL = 4'd12,
    ALU_ROR = 4'd13,
    ALU_CMP = 4'd14,
    ALU_MUL = 4'd15
  } alu_mode_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int NFLAGS = 4;

endpackage

// File: rtl/alu_mul.sv
// N-iteration shift-add unsigned multiplier.
// done/product describe the final step, captured by the parent at that edge.
module alu_mul
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  a_q;
  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [N:0]    sum;

  assign sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
  assign done = busy_q && (cnt_q == CW'(N - 1));
  assign product = {sum, lo_q[N-1:1]};
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      {hi_q, lo_q} <= {sum, lo_q[N-1:1]};
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      hi_q   <= '0;
      lo_q   <= b;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered N-bit ALU with full flag set and optional
// multi-cycle multiply behind a busy/done handshake.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N      = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [3:0]   mode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] out,
  output logic [N-1:0] out_hi,
  output logic         busy,
  output logic         done,
  output logic         flag_zero,
  output logic         flag_carry,
  output logic         flag_neg,
  output logic         flag_ovf
);

  logic [N-1:0]      out_q, out_d;
  logic [N-1:0]      hi_q, hi_d;
  logic [NFLAGS-1:0] flg_q, flg_d;
  logic              done_q, done_d;
  logic              accept;
  logic              mul_busy, mul_done;
  logic [2*N-1:0]    mul_prod;

  assign accept = enable && !mul_busy;

  if (MUL_EN) begin : g_mul
    alu_mul #(.N(N)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (accept && (mode == ALU_MUL)),
      .a       (in_a),
      .b       (in_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
    );
  end else begin : g_nomul
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  logic [N:0] a1, b1, r;
  logic       cin, c, v, wr, upd;

  always_comb begin
    out_d  = out_q;
    hi_d   = hi_q;
    flg_d  = flg_q;
    done_d = 1'b0;
    a1     = {1'b0, in_a};
    b1     = {1'b0, in_b};
    cin    = flg_q[FLAG_C];
    r      = '0;
    c      = 1'b0;
    v      = 1'b0;
    wr     = 1'b1;
    upd    = 1'b1;
    if (mul_done) begin
      out_d         = mul_prod[N-1:0];
      hi_d          = mul_prod[2*N-1:N];
      flg_d[FLAG_Z] = (mul_prod == '0);
      flg_d[FLAG_C] = |mul_prod[2*N-1:N];
      flg_d[FLAG_N] = mul_prod[2*N-1];
      flg_d[FLAG_V] = 1'b0;
      done_d        = 1'b1;
    end else if (accept) begin
      done_d = 1'b1;
      unique case (alu_mode_e'(mode))
        ALU_ADD, ALU_ADC: begin
          r = a1 + b1 + {{N{1'b0}}, (mode == ALU_ADC) & cin};
          c = r[N];
          v = ~(in_a[N-1] ^ in_b[N-1]) & (r[N-1] ^ in_a[N-1]);
        end
        ALU_SUB, ALU_SBC, ALU_CMP: begin
          r  = a1 - b1 - {{N{1'b0}}, (mode == ALU_SBC) & cin};
          c  = r[N];
          v  = (in_a[N-1] ^ in_b[N-1]) & (r[N-1] ^ in_a[N-1]);
          wr = (mode != ALU_CMP);
        end
        ALU_INC: begin
          r = a1 + 1'b1;
          c = r[N];
          v = ~in_a[N-1] & r[N-1];
        end
        ALU_DEC: begin
          r = a1 - 1'b1;
          c = r[N];
          v = in_a[N-1] & ~r[N-1];
        end
        ALU_AND: r = a1 & b1;
        ALU_OR:  r = a1 | b1;
        ALU_XOR: r = a1 ^ b1;
        ALU_NOT: r = {1'b0, ~in_a};
        ALU_SHL: begin
          r = {1'b0, in_a[N-2:0], 1'b0};
          c = in_a[N-1];
        end
        ALU_SHR: begin
          r = {2'b00, in_a[N-1:1]};
          c = in_a[0];
        end
        ALU_ROL: begin
          r = {1'b0, in_a[N-2:0], in_a[N-1]};
          c = in_a[N-1];
        end
        ALU_ROR: begin
          r = {1'b0, in_a[0], in_a[N-1:1]};
          c = in_a[0];
        end
        ALU_MUL: begin
          // with the multiplier present, results arrive via mul_done
          wr     = 1'b0;
          upd    = 1'b0;
          done_d = !MUL_EN;
        end
      endcase
      if (upd) begin
        flg_d[FLAG_Z] = (r[N-1:0] == '0);
        flg_d[FLAG_C] = c;
        flg_d[FLAG_N] = r[N-1];
        flg_d[FLAG_V] = v;
      end
      if (wr) begin
        out_d = r[N-1:0];
        hi_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q  <= '0;
      hi_q   <= '0;
      flg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      hi_q   <= hi_d;
      flg_q  <= flg_d;
      done_q <= done_d;
    end
  end

  assign out        = out_q;
  assign out_hi     = hi_q;
  assign busy       = mul_busy;
  assign done       = done_q;
  assign flag_zero  = flg_q[FLAG_Z];
  assign flag_carry = flg_q[FLAG_C];
  assign flag_neg   = flg_q[FLAG_N];
  assign flag_ovf   = flg_q[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic [3:0]   mode = '0;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic [N-1:0] out, out_hi;
  logic         busy, done, fz, fc, fn, fv;

  logic         e0 = 1'b0;
  logic [3:0]   m0 = '0;
  logic [N-1:0] a0 = '0, b0 = '0;
  logic [N-1:0] out0, hi0;
  logic         busy0, done0, fz0, fc0, fn0, fv0;

  always #5 clk = ~clk;

  alu_seq #(.N(N), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .in_a(in_a), .in_b(in_b), .out(out), .out_hi(out_hi),
    .busy(busy), .done(done), .flag_zero(fz), .flag_carry(fc),
    .flag_neg(fn), .flag_ovf(fv)
  );

  alu_seq #(.N(N), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(e0), .mode(m0),
    .in_a(a0), .in_b(b0), .out(out0), .out_hi(hi0),
    .busy(busy0), .done(done0), .flag_zero(fz0), .flag_carry(fc0),
    .flag_neg(fn0), .flag_ovf(fv0)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  o;
    logic [7:0]  h;
    logic [3:0]  f;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] m_out = '0, m_hi = '0;
  logic [3:0] m_f = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // flags packed as {ovf, neg, carry, zero}
  function automatic void model(input int m, input int a, input int b);
    int s, t, bb, ci, res, p;
    bit c, v, cmp;
    res = 0; c = 0; v = 0; cmp = 0;
    case (m)
      0, 2, 7: begin
        bb  = (m == 2) ? 1 : b;
        ci  = (m == 7) ? int'(m_f[1]) : 0;
        s   = a + bb + ci;
        res = s & 255;
        c   = (s > 255);
        t   = sx(a) + sx(bb) + ci;
        v   = (t > 127) || (t < -128);
      end
      1, 3, 8, 14: begin
        bb  = (m == 3) ? 1 : b;
        ci  = (m == 8) ? int'(m_f[1]) : 0;
        s   = a - bb - ci;
        res = s & 255;
        c   = (a < bb + ci);
        t   = sx(a) - sx(bb) - ci;
        v   = (t > 127) || (t < -128);
        cmp = (m == 14);
      end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      9: res = (~a) & 255;
      10: begin res = (a << 1) & 255; c = bit'(a >> 7); end
      11: begin res = a >> 1; c = bit'(a & 1); end
      12: begin res = ((a << 1) | (a >> 7)) & 255; c = bit'(a >> 7); end
      13: begin res = (a >> 1) | ((a & 1) << 7); c = bit'(a & 1); end
      default: begin
        p    = a * b;
        m_out = 8'(p & 255);
        m_hi  = 8'(p >> 8);
        m_f   = {1'b0, m_hi[7], (m_hi != 0), (p == 0)};
        return;
      end
    endcase
    m_f = {v, (res >= 128), c, (res == 0)};
    if (!cmp) begin
      m_out = 8'(res);
      m_hi  = '0;
    end
  endfunction

  // entered and left at a negedge
  task automatic issue(input int m, input int a, input int b);
    exp_t e;
    enable = 1'b1;
    mode   = 4'(m);
    in_a   = 8'(a);
    in_b   = 8'(b);
    model(m, a, b);
    e.cyc = 32'(cyc + 1 + ((m == 15) ? N : 0));
    e.o = m_out;
    e.h = m_hi;
    e.f = m_f;
    q.push_back(e);
    @(negedge clk);
    enable = 1'b0;
    if (m == 15) begin
      for (int i = 0; i < N; i++) begin
        chk("mul_busy", int'(busy), 1);
        enable = 1'($urandom);
        mode   = 4'($urandom);
        in_a   = 8'($urandom);
        in_b   = 8'($urandom);
        @(negedge clk);
      end
      enable = 1'b0;
      chk("mul_busy_end", int'(busy), 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, int'(e.cyc));
        chk("out", int'(out), int'(e.o));
        chk("out_hi", int'(out_hi), int'(e.h));
        chk("flags", int'({fv, fn, fc, fz}), int'(e.f));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  function automatic int pick();
    int s;
    s = $urandom_range(0, 7);
    case (s)
      0: return 0;
      1: return 255;
      2: return 127;
      3: return 128;
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_hi", int'(out_hi), 0);
    chk("rst_flags", int'({fv, fn, fc, fz}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(0, 8'hFF, 8'h01);
    chk("add_ff_out", int'(out), 0);
    chk("add_ff_zc", int'({fz, fc, fv}), 3'b110);
    issue(7, 0, 0);
    chk("adc_out", int'(out), 1);
    chk("adc_c", int'(fc), 0);
    issue(0, 8'h7F, 8'h01);
    chk("add_ovf", int'({out, fn, fv, fc}), {8'h80, 3'b110});
    issue(1, 0, 1);
    chk("sub_borrow", int'({out, fc, fn}), {8'hFF, 2'b11});
    issue(8, 5, 2);
    chk("sbc_out", int'(out), 2);
    issue(10, 8'h81, 0);
    chk("shl", int'({out, fc}), {8'h02, 1'b1});
    issue(13, 8'h01, 0);
    chk("ror", int'({out, fc}), {8'h80, 1'b1});
    issue(14, 8'h10, 8'h10);
    chk("cmp_hold", int'({out, fz}), {8'h80, 1'b1});
    issue(15, 8'hFF, 8'hFF);
    chk("mul_ff", int'({out_hi, out, fc}), {16'hFE01, 1'b1});

    e0 = 1'b1; m0 = 4'd0; a0 = 8'h7F; b0 = 8'h01;
    @(negedge clk);
    chk("nomul_add", int'({out0, fv0, fn0}), {8'h80, 2'b11});
    m0 = 4'd15; a0 = 8'd5; b0 = 8'd6;
    @(negedge clk);
    e0 = 1'b0;
    chk("nomul_done", int'(done0), 1);
    chk("nomul_busy", int'(busy0), 0);
    chk("nomul_hold", int'({out0, hi0, fv0, fn0, fc0, fz0}),
        {8'h80, 8'h00, 4'b1100});
    @(negedge clk);
    chk("nomul_pulse", int'(done0), 0);

    enable = 1'b1; mode = 4'd15; in_a = 8'h12; in_b = 8'h34;
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_out", int'({out, out_hi}), 0);
    chk("abort_flags", int'({fv, fn, fc, fz}), 0);
    chk("abort_done", int'(done), 0);
    m_out = '0; m_hi = '0; m_f = '0;
    issue(15, 3, 4);
    chk("mul_3x4", int'({out_hi, out, fc}), {16'h000C, 1'b0});

    for (int i = 0; i < 200; i++) begin
      issue(int'($urandom_range(0, 15)), pick(), pick());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
